alarm_setter: RTL
=================

Name: alarm_setter

Overview:
- Button-driven controller that produces the stored alarm time (alarm_hours, alarm_mins) consumed by the alarm-match comparator.
- The user steps through hours, then minutes, using set/up/down buttons.
- Edits go to shadow registers and are committed only on completion. An inactivity timeout cancels the edit.
- Provides edit values and a blink strobe so the display can show the field being edited.

Parameters:
- HOLD_CYCLES, 50000000: cycles a single up/down must stay held before auto-repeat starts.
- REPEAT_CYCLES, 12500000: cycles between auto-repeat steps once repeating.
- BLINK_CYCLES, 25000000: half-period of the blink output, in cycles.
- TIMEOUT_CYCLES, 1000000000: idle cycles in an edit state before the edit is cancelled.
- RESET_HOURS, 6: alarm_hours value after reset.
- RESET_MINS, 0: alarm_mins value after reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- set_btn  in  1  debounced, asynchronous set button level.
- up_btn  in  1  debounced, asynchronous increment button level.
- down_btn  in  1  debounced, asynchronous decrement button level.
- alarm_hours  out  6  committed alarm hours, 0..23.
- alarm_mins  out  6  committed alarm minutes, 0..59.
- edit_hours  out  6  shadow hours shown while editing.
- edit_mins  out  6  shadow minutes shown while editing.
- editing  out  2  edit state: 00 IDLE, 01 SET_HOURS, 10 SET_MINS; 11 never driven.
- blink  out  1  display blink strobe for the active field.
- alarm_updated  out  1  one-cycle pulse on commit.

Behaviour:
- Reset (rst_n low, asynchronous):
  - alarm_hours=edit_hours=RESET_HOURS, alarm_mins=edit_mins=RESET_MINS.
  - editing=00, blink=0, alarm_updated=0.
  - All synchronizers, counters and edge registers cleared.
- Reset mid-edit discards the shadow values. Release is sampled synchronously by the next clk edge.
- Input path:
  - Each button goes through a 2-flop synchronizer, then a previous-value register.
  - rise = s2 & ~prev.
  - An input going high before clk edge N produces its action at edge N+2; outputs show it after edge N+2.
- FSM:
  - IDLE: rise(set) copies alarm_* into edit_* and goes to SET_HOURS. up/down are ignored.
  - SET_HOURS: rise(set) goes to SET_MINS.
  - SET_MINS: rise(set) copies edit_* into alarm_*, pulses alarm_updated the same cycle, and goes to IDLE.
  - Timeout: in SET_HOURS or SET_MINS, TIMEOUT_CYCLES consecutive cycles with no rise on any button returns to IDLE. alarm_* is unchanged and edit_* is reloaded from alarm_*.
- Stepping:
  - Applies to edit_hours in SET_HOURS and edit_mins in SET_MINS.
  - Up step: +1, with hours wrapping 23->0 and minutes 59->0.
  - Down step: -1, with hours wrapping 0->23 and minutes 0->59.
  - No intermediate value ever leaves the legal range.
- Step triggers:
  - A rise on exactly one of up/down steps once and clears the hold counter.
  - While that one button stays high (synced level), the hold counter increments each cycle.
  - At count HOLD_CYCLES, one step is taken and auto-repeat starts. Each further REPEAT_CYCLES produces one step.
  - Releasing the button, or both up and down high, stops repeating and clears the counter.
- Simultaneous events:
  - up and down both high, or rising together: no step.
  - rise(set) together with an up/down step: set wins, no step that cycle. The hold counter clears on any state change.
- blink:
  - 0 in IDLE.
  - In an edit state it toggles every BLINK_CYCLES cycles, starting at 1 on state entry.
  - Any step forces blink=1 and restarts its counter, so the value stays visible while changing.
- The timeout counter clears on any rise and on state entry.
- Counters are wide enough for their parameter (clog2). No counter ever wraps unintentionally.

Test Plan:
Benches use HOLD_CYCLES=8, REPEAT_CYCLES=4, BLINK_CYCLES=3, TIMEOUT_CYCLES=50.
1. Reset: pulse rst_n low mid-cycle -> outputs immediately 06:00, editing=00, blink=0, alarm_updated=0.
2. Basic set: set, up x3, set, up x2, set (each a 1-cycle-gap press) -> alarm 09:02; alarm_updated high exactly 1 cycle; editing returns 00. Check the 2-edge input latency.
3. Wrap: from 23:59, edit with up once on each field -> 00:00. Then edit with down on each -> 23:59.
4. Auto-repeat: hold up 30 cycles in SET_MINS from 00 -> steps at rise, +8, +12, +16, +20, +24, +28 -> edit_mins=7. Holding up and down together gives no steps.
5. Timeout: enter SET_HOURS, step to 10, idle 50 cycles -> editing=00, alarm_hours still 06, edit_hours=06, no alarm_updated.
6. Priority and reset: rise(set) and rise(up) on the same sample in SET_HOURS -> SET_MINS, edit_hours unchanged. Assert rst_n mid-SET_MINS -> committed values return to reset defaults.

Source files
------------

// File: rtl/alarm_setter.sv
// Alarm-time setter: set/up/down buttons edit hours then minutes in shadow
// registers; the committed alarm only changes when the minutes field is confirmed.
module alarm_setter #(
  parameter int HOLD_CYCLES    = 50000000,
  parameter int REPEAT_CYCLES  = 12500000,
  parameter int BLINK_CYCLES   = 25000000,
  parameter int TIMEOUT_CYCLES = 1000000000,
  parameter int RESET_HOURS    = 6,
  parameter int RESET_MINS     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_btn,
  input  logic       up_btn,
  input  logic       down_btn,
  output logic [5:0] alarm_hours,
  output logic [5:0] alarm_mins,
  output logic [5:0] edit_hours,
  output logic [5:0] edit_mins,
  output logic [1:0] editing,
  output logic       blink,
  output logic       alarm_updated
);

  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W  = $clog2(RPT_MAX + 1);
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LIM  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]  RPT_LIM   = HOLD_W'(REPEAT_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LIM = BLINK_W'(BLINK_CYCLES);
  localparam logic [TMO_W-1:0]   TMO_LIM   = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [5:0]         RST_H     = 6'(RESET_HOURS);
  localparam logic [5:0]         RST_M     = 6'(RESET_MINS);
  localparam logic [5:0]         MAX_H     = 6'd23;
  localparam logic [5:0]         MAX_M     = 6'd59;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SET_HOURS = 2'b01,
    SET_MINS  = 2'b10
  } state_t;

  state_t state, state_n;

  // {set, up, down}: p0/p1 synchronize, p2 holds the previous synced level
  logic [2:0] btn_p0, btn_p1, btn_p2;
  logic [2:0] rise;
  logic       lvl_up, lvl_dn, single, any_rise, step;

  logic [HOLD_W-1:0]  hold_cnt, hold_n, hold_inc;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_n, blink_inc;
  logic [TMO_W-1:0]   tmo_cnt, tmo_n, tmo_inc;
  logic               repeating, rpt_n;
  logic [5:0]         ah_n, am_n, eh_n, em_n;
  logic               blink_n, upd_n;

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic up,
                                           input logic [5:0] top);
    if (up)
      return (v >= top) ? 6'd0 : v + 6'd1;
    else
      return (v == 6'd0 || v > top) ? top : v - 6'd1;
  endfunction

  assign rise      = btn_p1 & ~btn_p2;
  assign lvl_up    = btn_p1[1];
  assign lvl_dn    = btn_p1[0];
  assign single    = lvl_up ^ lvl_dn;
  assign any_rise  = |rise;
  assign hold_inc  = hold_cnt + HOLD_W'(1);
  assign blink_inc = blink_cnt + BLINK_W'(1);
  assign tmo_inc   = tmo_cnt + TMO_W'(1);
  assign editing   = state;

  always_comb begin
    state_n     = state;
    ah_n        = alarm_hours;
    am_n        = alarm_mins;
    eh_n        = edit_hours;
    em_n        = edit_mins;
    upd_n       = 1'b0;
    blink_n     = blink;
    blink_cnt_n = blink_cnt;
    tmo_n       = tmo_cnt;
    hold_n      = '0;
    rpt_n       = 1'b0;
    step        = 1'b0;

    // A single held button: step on its rise, then after HOLD, then every REPEAT
    if (single) begin
      if (rise[1] | rise[0]) begin
        step = 1'b1;
      end else if (!repeating && hold_inc == HOLD_LIM) begin
        step  = 1'b1;
        rpt_n = 1'b1;
      end else if (repeating && hold_inc == RPT_LIM) begin
        step  = 1'b1;
        rpt_n = 1'b1;
      end else begin
        hold_n = hold_inc;
        rpt_n  = repeating;
      end
    end

    case (state)
      IDLE: begin
        hold_n      = '0;
        rpt_n       = 1'b0;
        blink_cnt_n = '0;
        tmo_n       = '0;
        blink_n     = 1'b0;
        if (rise[2]) begin
          eh_n    = alarm_hours;
          em_n    = alarm_mins;
          state_n = SET_HOURS;
          blink_n = 1'b1;
        end
      end
      SET_HOURS, SET_MINS: begin
        if (rise[2]) begin
          hold_n      = '0;
          rpt_n       = 1'b0;
          tmo_n       = '0;
          blink_cnt_n = '0;
          if (state == SET_HOURS) begin
            state_n = SET_MINS;
            blink_n = 1'b1;
          end else begin
            ah_n    = edit_hours;
            am_n    = edit_mins;
            upd_n   = 1'b1;
            state_n = IDLE;
            blink_n = 1'b0;
          end
        end else if (!any_rise && tmo_inc == TMO_LIM) begin
          state_n     = IDLE;
          eh_n        = alarm_hours;
          em_n        = alarm_mins;
          hold_n      = '0;
          rpt_n       = 1'b0;
          tmo_n       = '0;
          blink_cnt_n = '0;
          blink_n     = 1'b0;
        end else begin
          tmo_n = any_rise ? '0 : tmo_inc;
          if (step) begin
            // keep the field lit while its value is changing
            blink_n     = 1'b1;
            blink_cnt_n = '0;
            if (state == SET_HOURS)
              eh_n = wrap_step(edit_hours, lvl_up, MAX_H);
            else
              em_n = wrap_step(edit_mins, lvl_up, MAX_M);
          end else if (blink_inc == BLINK_LIM) begin
            blink_n     = ~blink;
            blink_cnt_n = '0;
          end else begin
            blink_cnt_n = blink_inc;
          end
        end
      end
      default: begin
        state_n     = IDLE;
        hold_n      = '0;
        rpt_n       = 1'b0;
        blink_cnt_n = '0;
        tmo_n       = '0;
        blink_n     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0        <= '0;
      btn_p1        <= '0;
      btn_p2        <= '0;
      state         <= IDLE;
      alarm_hours   <= RST_H;
      alarm_mins    <= RST_M;
      edit_hours    <= RST_H;
      edit_mins     <= RST_M;
      alarm_updated <= 1'b0;
      blink         <= 1'b0;
      blink_cnt     <= '0;
      tmo_cnt       <= '0;
      hold_cnt      <= '0;
      repeating     <= 1'b0;
    end else begin
      btn_p0        <= {set_btn, up_btn, down_btn};
      btn_p1        <= btn_p0;
      btn_p2        <= btn_p1;
      state         <= state_n;
      alarm_hours   <= ah_n;
      alarm_mins    <= am_n;
      edit_hours    <= eh_n;
      edit_mins     <= em_n;
      alarm_updated <= upd_n;
      blink         <= blink_n;
      blink_cnt     <= blink_cnt_n;
      tmo_cnt       <= tmo_n;
      hold_cnt      <= hold_n;
      repeating     <= rpt_n;
    end
  end

endmodule
